// File: rtl/instr_assembler_pkg.sv
// Shared microarchitecture definitions: opcode encoding, assembler state and defaults.
package instr_assembler_pkg;

    localparam int DATA_W_DEFAULT   = 8;
    localparam int OPCODE_W_DEFAULT = 4;
    localparam int MAX_EXT_DEFAULT  = 2;

    // Opcode encoding of the upper nibble of the first instruction byte.
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_ADD  = 4'h4,
        OP_JMP  = 4'h5,
        OP_BEQ  = 4'h6,
        OP_CALL = 4'h7,
        OP_RET  = 4'h8,
        OP_AND  = 4'h9,
        OP_OR   = 4'hA,
        OP_XOR  = 4'hB,
        OP_SHL  = 4'hC,
        OP_SHR  = 4'hD,
        OP_CMP  = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    // Instruction assembler state: waiting for a first byte, gathering
    // extension bytes, or holding a complete instruction.
    typedef enum logic [1:0] {
        IR_EMPTY   = 2'd0,
        IR_COLLECT = 2'd1,
        IR_FULL    = 2'd2
    } ir_state_t;

endpackage

// File: rtl/instr_assembler.sv
// Instruction assembler: gathers a first byte plus up to MAX_EXT extension
// bytes from the fetch stream and presents the complete instruction with a
// valid/ready handshake. A retiring instruction and the next first byte can
// share a cycle, so back-to-back instructions leave no bubble.
module instr_assembler
    import instr_assembler_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int OPCODE_W = OPCODE_W_DEFAULT,
    parameter int MAX_EXT  = MAX_EXT_DEFAULT,
    parameter int CNT_W    = $clog2(MAX_EXT + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        byte_valid,
    input  logic [DATA_W-1:0]           byte_in,
    input  logic [CNT_W-1:0]            ext_count,
    output logic                        byte_ready,
    input  logic                        flush,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [OPCODE_W-1:0]         opcode,
    output logic [DATA_W-OPCODE_W-1:0]  operand,
    output logic [MAX_EXT*DATA_W-1:0]   ext_data,
    output logic [CNT_W-1:0]            ext_len,
    output logic                        len_error
);

    localparam int OPND_W = DATA_W - OPCODE_W;
    localparam int EXT_W  = MAX_EXT * DATA_W;
    localparam logic [CNT_W-1:0] MAX_EXT_C = CNT_W'(MAX_EXT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    ir_state_t            state_r;
    ir_state_t            state_n_s;
    logic [CNT_W-1:0]     slot_r;
    logic [CNT_W-1:0]     slot_n_s;
    logic [OPCODE_W-1:0]  opcode_r;
    logic [OPCODE_W-1:0]  opcode_n_s;
    logic [OPND_W-1:0]    operand_r;
    logic [OPND_W-1:0]    operand_n_s;
    logic [EXT_W-1:0]     ext_data_r;
    logic [EXT_W-1:0]     ext_data_n_s;
    logic [CNT_W-1:0]     ext_len_r;
    logic [CNT_W-1:0]     ext_len_n_s;
    logic                 len_error_r;
    logic                 len_error_n_s;

    logic                 accept_s;
    logic                 load_first_s;
    logic                 over_s;
    logic [CNT_W-1:0]     clamp_len_s;

    // A held instruction blocks new bytes unless it is being retired now.
    assign byte_ready  = (state_r != IR_FULL) || instr_ready;
    assign accept_s    = byte_valid && byte_ready && !flush;
    assign over_s      = (ext_count > MAX_EXT_C);
    assign clamp_len_s = over_s ? MAX_EXT_C : ext_count;

    assign instr_valid = (state_r == IR_FULL);
    assign opcode      = opcode_r;
    assign operand     = operand_r;
    assign ext_data    = ext_data_r;
    assign ext_len     = ext_len_r;
    assign len_error   = len_error_r;

    // Next-state and datapath update; flush wins over every handshake input.
    always_comb begin
        state_n_s     = state_r;
        slot_n_s      = slot_r;
        opcode_n_s    = opcode_r;
        operand_n_s   = operand_r;
        ext_data_n_s  = ext_data_r;
        ext_len_n_s   = ext_len_r;
        len_error_n_s = 1'b0;
        load_first_s  = 1'b0;

        if (flush) begin
            state_n_s = IR_EMPTY;
            slot_n_s  = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IR_EMPTY: begin
                    if (accept_s) begin
                        load_first_s = 1'b1;
                    end else begin
                        state_n_s = IR_EMPTY;
                    end
                end
                IR_COLLECT: begin
                    if (accept_s) begin
                        ext_data_n_s[slot_r*DATA_W +: DATA_W] = byte_in;
                        if ((slot_r + ONE_C) == ext_len_r) begin
                            state_n_s = IR_FULL;
                            slot_n_s  = {CNT_W{1'b0}};
                        end else begin
                            slot_n_s = slot_r + ONE_C;
                        end
                    end else begin
                        state_n_s = IR_COLLECT;
                    end
                end
                IR_FULL: begin
                    if (instr_ready) begin
                        if (accept_s) begin
                            load_first_s = 1'b1;
                        end else begin
                            state_n_s = IR_EMPTY;
                        end
                    end else begin
                        state_n_s = IR_FULL;
                    end
                end
                default: begin
                    state_n_s = IR_EMPTY;
                    slot_n_s  = {CNT_W{1'b0}};
                end
            endcase

            if (load_first_s) begin
                opcode_n_s    = byte_in[DATA_W-1 -: OPCODE_W];
                operand_n_s   = byte_in[OPND_W-1:0];
                ext_len_n_s   = clamp_len_s;
                ext_data_n_s  = {EXT_W{1'b0}};
                slot_n_s      = {CNT_W{1'b0}};
                len_error_n_s = over_s;
                state_n_s     = (clamp_len_s == {CNT_W{1'b0}}) ? IR_FULL : IR_COLLECT;
            end else begin
                len_error_n_s = 1'b0;
            end
        end
    end

    // State, slot counter and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IR_EMPTY;
            slot_r      <= {CNT_W{1'b0}};
            opcode_r    <= {OPCODE_W{1'b0}};
            operand_r   <= {OPND_W{1'b0}};
            ext_data_r  <= {EXT_W{1'b0}};
            ext_len_r   <= {CNT_W{1'b0}};
            len_error_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            slot_r      <= slot_n_s;
            opcode_r    <= opcode_n_s;
            operand_r   <= operand_n_s;
            ext_data_r  <= ext_data_n_s;
            ext_len_r   <= ext_len_n_s;
            len_error_r <= len_error_n_s;
        end
    end

endmodule

// File: tb/tb_instr_assembler.sv
// Self-checking bench for instr_assembler: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_instr_assembler;

    logic        clk;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic [1:0]  ext_count;
    logic        byte_ready;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  opcode;
    logic [3:0]  operand;
    logic [15:0] ext_data;
    logic [1:0]  ext_len;
    logic        len_error;

    int total = 0;
    int bad   = 0;

    instr_assembler dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .ext_count  (ext_count),
        .byte_ready (byte_ready),
        .flush      (flush),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .opcode     (opcode),
        .operand    (operand),
        .ext_data   (ext_data),
        .ext_len    (ext_len),
        .len_error  (len_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic [1:0]  c;
        logic        r;
        logic        rdy;
        logic        iv;
        logic        le;
        logic [3:0]  op;
        logic [3:0]  opd;
        logic [15:0] ext;
        logic [1:0]  len;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] b, input logic [1:0] c,
                         input logic f, input logic r, input logic rst);
        byte_valid  = v;
        byte_in     = b;
        ext_count   = c;
        flush       = f;
        instr_ready = r;
        reset       = rst;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_instr(input string nm, input logic [3:0] op, input logic [3:0] opd,
                             input logic [15:0] ext, input logic [1:0] len);
        chk({nm, ".valid"}, {31'd0, instr_valid}, 32'd1);
        chk({nm, ".opcode"}, {28'd0, opcode}, {28'd0, op});
        chk({nm, ".operand"}, {28'd0, operand}, {28'd0, opd});
        chk({nm, ".ext_data"}, {16'd0, ext_data}, {16'd0, ext});
        chk({nm, ".ext_len"}, {30'd0, ext_len}, {30'd0, len});
    endtask

    // model state
    bit          m_full;
    bit          m_coll;
    bit          m_le;
    logic [3:0]  m_op;
    logic [3:0]  m_opd;
    int          m_need;
    logic [7:0]  m_q[$];

    function automatic logic [15:0] m_ext();
        logic [15:0] e = 16'h0000;
        for (int i = 0; i < m_q.size(); i++) e = e | (16'(m_q[i]) << (8 * i));
        return e;
    endfunction

    initial begin
        tbl[0] = '{1'b1, 8'h1A, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1, 4'hA, 16'h0000, 2'd0};
        tbl[1] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 4'hA, 16'h0000, 2'd0};
        tbl[2] = '{1'b1, 8'h3F, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 4'hF, 16'h0000, 2'd0};
        tbl[3] = '{1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000, 2'd0};
        tbl[4] = '{1'b1, 8'h70, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 16'h0000, 2'd0};
        tbl[5] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000, 2'd0};
        tbl[6] = '{1'b1, 8'hCD, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000, 2'd0};
        tbl[7] = '{1'b1, 8'hAB, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h7, 4'h0, 16'hABCD, 2'd2};
        tbl[8] = '{1'b1, 8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7, 4'h0, 16'hABCD, 2'd2};
        tbl[9] = '{1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000, 2'd0};

        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("reset.valid", {31'd0, instr_valid}, 32'd0);
        chk("reset.len_error", {31'd0, len_error}, 32'd0);
        chk("reset.outputs", {16'd0, opcode, operand, ext_len, 6'd0}, 32'd0);
        chk("reset.ext_data", {16'd0, ext_data}, 32'd0);
        chk("reset.byte_ready", {31'd0, byte_ready}, 32'd1);

        // directed vector table
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].b, tbl[i].c, 1'b0, tbl[i].r, 1'b0);
            #1;
            chk($sformatf("vec%0d.byte_ready", i), {31'd0, byte_ready}, {31'd0, tbl[i].rdy});
            tick();
            chk($sformatf("vec%0d.valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].iv});
            chk($sformatf("vec%0d.len_error", i), {31'd0, len_error}, {31'd0, tbl[i].le});
            if (tbl[i].iv) begin
                chk_instr($sformatf("vec%0d", i), tbl[i].op, tbl[i].opd, tbl[i].ext, tbl[i].len);
            end
        end

        // three-byte instruction held for five cycles while the consumer stalls
        drive(1'b1, 8'h52, 2'd2, 1'b0, 1'b0, 1'b0); tick();
        chk("hold.collect1", {31'd0, instr_valid}, 32'd0);
        drive(1'b1, 8'h34, 2'd0, 1'b0, 1'b0, 1'b0); tick();
        chk("hold.collect2", {31'd0, instr_valid}, 32'd0);
        drive(1'b1, 8'h12, 2'd0, 1'b0, 1'b0, 1'b0); tick();
        chk_instr("hold.done", 4'h5, 4'h2, 16'h1234, 2'd2);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i * 37 + 5), 2'd1, 1'b0, 1'b0, 1'b0);
            #1;
            chk("hold.byte_ready", {31'd0, byte_ready}, 32'd0);
            tick();
            chk_instr("hold.stable", 4'h5, 4'h2, 16'h1234, 2'd2);
        end

        // reset while holding a complete instruction
        drive(1'b1, 8'hEE, 2'd1, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0); #1;
        chk("rstfull.valid", {31'd0, instr_valid}, 32'd0);
        chk("rstfull.outputs", {16'd0, opcode, operand, ext_len, 6'd0}, 32'd0);
        chk("rstfull.ext_data", {16'd0, ext_data}, 32'd0);
        chk("rstfull.byte_ready", {31'd0, byte_ready}, 32'd1);

        // flush mid-collect, byte presented with flush is dropped
        drive(1'b1, 8'h52, 2'd2, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h34, 2'd0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h99, 2'd0, 1'b1, 1'b1, 1'b0); tick();
        chk("flush.valid", {31'd0, instr_valid}, 32'd0);
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0); tick();
        chk("flush.idle", {31'd0, instr_valid}, 32'd0);
        drive(1'b1, 8'h1A, 2'd0, 1'b0, 1'b0, 1'b0); tick();
        chk_instr("flush.fresh", 4'h1, 4'hA, 16'h0000, 2'd0);

        // randomized traffic against the reference model
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1); tick();
        m_full = 1'b0; m_coll = 1'b0; m_le = 1'b0;
        m_op = 4'h0; m_opd = 4'h0; m_need = 0; m_q.delete();
        for (int n = 0; n < 3000; n++) begin
            logic       v, f, r, rst, exp_rdy, acc;
            logic [7:0] b;
            logic [1:0] c;
            int         cw;
            v   = ($urandom_range(0, 3) != 0);
            f   = ($urandom_range(0, 15) == 0);
            r   = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 63) == 0);
            b   = 8'($urandom);
            cw  = $urandom_range(0, 3);
            c   = 2'(cw);
            drive(v, b, c, f, r, rst);
            #1;
            exp_rdy = !m_full || r;
            chk("rand.byte_ready", {31'd0, byte_ready}, {31'd0, exp_rdy});
            if (rst || f) begin
                m_full = 1'b0; m_coll = 1'b0; m_le = 1'b0;
            end else begin
                acc  = v && exp_rdy;
                m_le = 1'b0;
                if (m_full && r) m_full = 1'b0;
                if (acc) begin
                    if (!m_coll) begin
                        m_op   = b[7:4];
                        m_opd  = b[3:0];
                        m_need = (cw > 2) ? 2 : cw;
                        m_le   = (cw > 2);
                        m_q.delete();
                        if (m_need == 0) m_full = 1'b1;
                        else m_coll = 1'b1;
                    end else begin
                        m_q.push_back(b);
                        if (m_q.size() == m_need) begin
                            m_full = 1'b1;
                            m_coll = 1'b0;
                        end
                    end
                end
            end
            tick();
            chk("rand.valid", {31'd0, instr_valid}, {31'd0, m_full});
            chk("rand.len_error", {31'd0, len_error}, {31'd0, m_le});
            if (rst) begin
                chk("rand.reset_outputs", {opcode, operand, ext_data, ext_len, 6'd0}, 32'd0);
            end
            if (m_full) begin
                chk_instr("rand", m_op, m_opd, m_ext(), 2'(m_need));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_assembler.md
INSTR_ASSEMBLER -- requirements
Module: instr_assembler

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of each fetched byte.
REQ-002 SHALL have parameter OPCODE_W, default 4, meaning opcode field width (upper bits of first byte); operand field is the remaining DATA_W-OPCODE_W lower bits.
REQ-003 SHALL have parameter MAX_EXT, default 2, meaning maximum extension (immediate/address) bytes per instruction; CNT_W = $clog2(MAX_EXT+1).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-005 byte_valid  input  1  fetch byte present on byte_in.
REQ-006 byte_in  input  DATA_W  fetched byte.
REQ-007 ext_count  input  CNT_W  extension byte count from the external length decoder; sampled only with the first byte.
REQ-008 byte_ready  output  1  assembler accepts byte_in this cycle.
REQ-009 flush  input  1  discard partial/held instruction (branch taken).
REQ-010 instr_valid  output  1  complete instruction held on outputs.
REQ-011 instr_ready  input  1  consumer takes the instruction this cycle.
REQ-012 opcode  output  OPCODE_W  opcode field of first byte.
REQ-013 operand  output  DATA_W-OPCODE_W  operand field of first byte.
REQ-014 ext_data  output  MAX_EXT*DATA_W  extension bytes, first extension byte in bits [DATA_W-1:0].
REQ-015 ext_len  output  CNT_W  number of valid extension bytes.
REQ-016 len_error  output  1  one-cycle pulse: ext_count > MAX_EXT seen on a first byte.

Function
REQ-017 A byte SHALL be accepted at a rising edge iff byte_valid && byte_ready && !flush.
REQ-018 FSM states SHALL be EMPTY, COLLECT, FULL.
REQ-019 EMPTY: accepted byte latches opcode/operand, ext_len<=ext_count, clears ext_data; ext_count==0 -> FULL, else -> COLLECT.
REQ-020 COLLECT: accepted byte written to slot index k (k = bytes already collected, 0-based); when k+1==ext_len -> FULL, else stay.
REQ-021 FULL: instr_valid=1; instr_ready=1 -> instruction retired; simultaneously accepted byte is treated as an EMPTY-state first byte (back-to-back, no bubble); no byte -> EMPTY.
REQ-022 byte_ready SHALL be 1 in EMPTY and COLLECT, and in FULL equal to instr_ready (combinational).
REQ-023 instr_valid SHALL be 1 exactly in FULL; latency: asserts the cycle after the edge accepting the last byte (single-byte instruction: 1 cycle).
REQ-024 Outputs opcode/operand/ext_data/ext_len SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-025 Unused ext_data slots (index >= ext_len) SHALL read 0.
REQ-026 ext_count > MAX_EXT SHALL clamp ext_len to MAX_EXT and pulse len_error for the cycle after acceptance.
REQ-027 flush SHALL at the next edge force EMPTY, instr_valid=0, slot index 0; byte presented with flush is dropped; flush overrides instr_ready and byte_valid.
REQ-028 byte_valid gaps in COLLECT SHALL hold state and partial data indefinitely.

Reset
REQ-029 reset SHALL, at the next rising edge, force EMPTY, instr_valid=0, opcode/operand/ext_data/ext_len=0, len_error=0, slot index 0; reset overrides flush and all inputs.
REQ-030 reset mid-COLLECT or in FULL SHALL discard the instruction; no retirement is signalled.
REQ-031 byte_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 State enum (ir_state_t) and default MAX_EXT constant SHALL be added to the shared microarch definitions package alongside opcode_t.
REQ-033 With default OPCODE_W, opcode output SHALL be castable to opcode_t.
REQ-034 Single module, no sub-module; one state register, one slot counter, one datapath register set.

Verification
REQ-035 Reset, then byte 0x1A with ext_count=0 -> next cycle instr_valid=1, opcode=0x1, operand=0xA, ext_len=0, ext_data=0x0000.
REQ-036 Bytes 0x52(ext=2), 0x34, 0x12 with instr_ready=0 -> instr_valid after third byte, ext_data=0x1234, byte_ready=0, outputs held 5 cycles.
REQ-037 FULL with instr_ready=1 and byte 0x3F(ext=0) same cycle -> next cycle instr_valid=1, opcode=0x3, operand=0xF, no bubble.
REQ-038 First byte 0x70 with ext_count=3 (MAX_EXT=2) -> len_error one-cycle pulse, ext_len=2, two more bytes complete it.
REQ-039 Flush after 0x52,0x34 (mid-COLLECT) -> EMPTY, instr_valid stays 0; next 0x1A(ext=0) decodes as fresh instruction.
REQ-040 Reset asserted in FULL with instr_ready=0 -> next cycle instr_valid=0, all outputs 0, byte_ready=1.
